vga_ram_arbiter: RTL

//  Two-master round-robin arbiter in front of the single-port 8192x32 on-chip RAM.

---
 rtl/vga_ram_arb_pkg.sv | 21 ++
 rtl/vga_ram_rd_tag_pipe.sv | 45 ++++
 rtl/vga_ram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_ram_arb_pkg.sv
// Shared types and default widths for the VGA RAM arbiter slice.
//   ARB_ADDR_W / ARB_DATA_W / ARB_BE_W : default word-address, data and byte-lane widths
//   owner_t  : which master owns an access (OWN_M0 = FFT writer, OWN_M1 = VGA/CPU reader)
//   rd_tag_t : in-flight read tag {valid, owner}
package vga_ram_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 13;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/vga_ram_rd_tag_pipe.sv
// Read-tag delay line matching the RAM read latency.
//   clk, reset_n          : clock, asynchronous active-low clear (drops in-flight reads)
//   push_valid/push_owner : tag of a read granted this cycle
//   pop_valid/pop_owner   : tag whose RAM data is on ram_readdata this cycle
module vga_ram_rd_tag_pipe
  import vga_ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner
);

  rd_tag_t                push_tag;
  rd_tag_t [RD_LAT-1:0]   stage;

  assign push_tag.valid = push_valid;
  assign push_tag.owner = owner_t'(push_owner);

  if (RD_LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage <= '0;
      end else begin
        stage <= push_tag;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage <= '0;
      end else begin
        stage <= {stage[RD_LAT-2:0], push_tag};
      end
    end
  end

  assign pop_valid = stage[RD_LAT-1].valid;
  assign pop_owner = stage[RD_LAT-1].owner;

endmodule

// File: rtl/vga_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM.
//   m0_* : FFT result writer (Avalon-MM slave side)
//   m1_* : VGA/CPU reader   (Avalon-MM slave side)
//   ram_*: single-port RAM (address/byteenable/chipselect/write/writedata/clken out, readdata in)
// At most one access is granted per cycle; the loser sees waitrequest. Reads are tagged
// with their owner and readdata/readdatavalid is returned to that master RD_LAT cycles later.
module vga_ram_arbiter
  import vga_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned BE_W   = ARB_BE_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic              req0, req1;
  logic              grant0, grant1, any_grant;
  owner_t            last_grant;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_address, hold_address;
  logic [DATA_W-1:0] sel_writedata, hold_writedata;
  logic [BE_W-1:0]   sel_byteenable, hold_byteenable;
  logic              rd_pop_valid, rd_pop_owner;
  owner_t            rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant is combinational; reset_n gates it so nothing is granted while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        grant0 = (last_grant == OWN_M1);
        grant1 = (last_grant == OWN_M0);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign any_grant      = grant0 | grant1;
  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWN_M1;
    end else if (grant0) begin
      last_grant <= OWN_M0;
    end else if (grant1) begin
      last_grant <= OWN_M1;
    end
  end

  always_comb begin
    sel_address    = m0_address;
    sel_writedata  = m0_writedata;
    sel_read       = m0_read;
    sel_write      = m0_write;
    sel_byteenable = m0_write ? m0_byteenable : '1;
    if (grant1) begin
      sel_address    = m1_address;
      sel_writedata  = m1_writedata;
      sel_read       = m1_read;
      sel_write      = m1_write;
      sel_byteenable = m1_write ? m1_byteenable : '1;
    end
  end

  // Idle cycles replay the last granted address/data so the RAM bus stays quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_address    <= '0;
      hold_writedata  <= '0;
      hold_byteenable <= '0;
    end else if (any_grant) begin
      hold_address    <= sel_address;
      hold_writedata  <= sel_writedata;
      hold_byteenable <= sel_byteenable;
    end
  end

  assign ram_address    = any_grant ? sel_address    : hold_address;
  assign ram_writedata  = any_grant ? sel_writedata  : hold_writedata;
  assign ram_byteenable = any_grant ? sel_byteenable : hold_byteenable;
  assign ram_chipselect = any_grant;
  assign ram_write      = any_grant & sel_write;
  assign ram_clken      = 1'b1;

  // Read+write together is a write, so only pure reads get a return tag.
  vga_ram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (any_grant & sel_read & ~sel_write),
    .push_owner (grant1),
    .pop_valid  (rd_pop_valid),
    .pop_owner  (rd_pop_owner)
  );

  assign rd_owner         = owner_t'(rd_pop_owner);
  assign m0_readdatavalid = rd_pop_valid & (rd_owner == OWN_M0);
  assign m1_readdatavalid = rd_pop_valid & (rd_owner == OWN_M1);
  assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

endmodule
